i_cache_sa: RTL and testbench

//  Parametrised N-way set-associative, read-only L1 instruction cache with an integrated controller FSM.

---
 rtl/i_cache_sa.sv | 237 +++++++++++++++++++++++
 tb/tb_i_cache_sa.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : i_cache_sa
// Brief    : N-way set-associative read-only L1 instruction cache with
//            invalid-first / tree-PLRU replacement, line fill and flush.
// Revision : 1.0
// ============================================================================
module i_cache_sa #(
  parameter int NSETS     = 8,
  parameter int NWAYS     = 4,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_read,
  input  logic [ADDR_W-1:0]    cpu_addr,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_resp,
  input  logic                 flush,
  output logic                 flush_ack,
  output logic                 mem_read,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_resp,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(NSETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(NWAYS);
  localparam int NWORDS = LINE_BITS / 32;
  localparam int WSEL_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:2]           addr_q, addr_d;
  logic                        refill_q, refill_d;
  logic [WAY_W-1:0]            victim_q, victim_d;
  logic                        cpu_resp_q, cpu_resp_d;
  logic [31:0]                 cpu_rdata_q, cpu_rdata_d;
  logic                        flush_ack_q, flush_ack_d;
  logic                        mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [31:0]                 hit_count_q, hit_count_d;
  logic [31:0]                 miss_count_q, miss_count_d;
  logic [NSETS-1:0][NWAYS-1:0] valid_q, valid_d;
  // PLRU tree per set in heap order: node n has children 2n and 2n+1, root is 1, bit 0 unused.
  logic [NSETS-1:0][NWAYS-1:0] plru_q, plru_d;
  logic [TAG_W-1:0]            tag_q  [NSETS][NWAYS];
  logic [TAG_W-1:0]            tag_d  [NSETS][NWAYS];
  logic [LINE_BITS-1:0]        data_q [NSETS][NWAYS];
  logic [LINE_BITS-1:0]        data_d [NSETS][NWAYS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  plru_way;
  logic [WAY_W:0]    vnode;
  logic [WAY_W:0]    unode;
  logic [31:0]       hit_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];

  generate
    if (NWORDS > 1) begin : g_wsel
      assign wsel = addr_q[2 +: WSEL_W];
    end else begin : g_wsel_single
      assign wsel = 1'b0;
    end
  endgenerate

  // Way search: descending loop so the lowest matching / invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][WAY_W'(w)] && (tag_q[idx][WAY_W'(w)] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Walk from the root following node bits; the leaf index minus NWAYS is the victim.
  always_comb begin
    vnode = {{WAY_W{1'b0}}, 1'b1};
    for (int l = 0; l < WAY_W; l++) begin
      vnode = {vnode[WAY_W-1:0], plru_q[idx][vnode[WAY_W-1:0]]};
    end
    plru_way = vnode[WAY_W-1:0];
  end

  always_comb begin
    hit_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (wsel == WSEL_W'(k)) begin
        hit_word = data_q[idx][hit_way][32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    refill_d     = refill_q;
    victim_d     = victim_q;
    cpu_resp_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    flush_ack_d  = 1'b0;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    plru_d       = plru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    unode        = {1'b1, hit_way};

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d     = '0;
          plru_d      = '0;
          flush_ack_d = 1'b1;
        end else if (cpu_read) begin
          addr_d   = cpu_addr[ADDR_W-1:2];
          refill_d = 1'b0;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_resp_d  = 1'b1;
          cpu_rdata_d = hit_word;
          // Point every node on the path away from the accessed leaf.
          for (int l = 0; l < WAY_W; l++) begin
            plru_d[idx][unode[WAY_W:1]] = ~unode[0];
            unode = unode >> 1;
          end
          // The lookup that closes a fill is the tail of a miss, not a new hit.
          if (!refill_q && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
          end
          state_d = S_IDLE;
        end else begin
          victim_d = inv_found ? inv_way : plru_way;
          if (miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
          end
          mem_read_d = 1'b1;
          mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_resp) begin
          data_d[idx][victim_q]  = mem_rdata;
          tag_d[idx][victim_q]   = tag;
          valid_d[idx][victim_q] = 1'b1;
          mem_read_d             = 1'b0;
          refill_d               = 1'b1;
          state_d                = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      refill_q     <= 1'b0;
      victim_q     <= '0;
      cpu_resp_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      flush_ack_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      valid_q      <= '0;
      plru_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      refill_q     <= refill_d;
      victim_q     <= victim_d;
      cpu_resp_q   <= cpu_resp_d;
      cpu_rdata_q  <= cpu_rdata_d;
      flush_ack_q  <= flush_ack_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
      plru_q       <= plru_d;
    end
  end

  // Tag and data arrays are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cpu_resp   = cpu_resp_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign flush_ack  = flush_ack_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_i_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_i_cache_sa
// Brief    : Directed self-checking bench for i_cache_sa (default parameters).
// Revision : 1.0
// ============================================================================
module tb_i_cache_sa;
  logic         clk;
  logic         rst;
  logic         cpu_read;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_rdata;
  logic         cpu_resp;
  logic         flush;
  logic         flush_ack;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  i_cache_sa #(
    .NSETS(8), .NWAYS(4), .LINE_BITS(256), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
    .flush(flush), .flush_ack(flush_ack),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Word i of the line at address la; the 0x1000 line holds 0xA0+i.
  function automatic logic [255:0] line_data(input logic [31:0] la);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'hA0 + 32'(i) + ((la ^ 32'h1000) << 8);
    return d;
  endfunction

  // Issue one fetch; memory answers on the third mem_read cycle.
  task automatic do_read(input string tag, input logic [31:0] addr, input bit miss, input bit hold);
    logic [31:0] line_a;
    logic [31:0] first_ma;
    logic [31:0] rd;
    logic [31:0] exp_word;
    int          cyc;
    int          mr_cyc;
    int          mresp_cyc;
    int          resp_cyc;
    bit          stable;
    line_a    = {addr[31:5], 5'b0};
    exp_word  = 32'hA0 + {29'b0, addr[4:2]} + ((line_a ^ 32'h1000) << 8);
    cyc       = 0;
    mr_cyc    = 0;
    mresp_cyc = -10;
    resp_cyc  = -1;
    stable    = 1'b1;
    first_ma  = '0;
    rd        = '0;
    cpu_addr  = addr;
    cpu_read  = 1'b1;
    while (resp_cyc < 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      mem_resp = 1'b0;
      if (cpu_resp) begin
        resp_cyc = cyc;
        rd       = cpu_rdata;
      end else if (mem_read) begin
        mr_cyc++;
        if (mr_cyc == 1) first_ma = mem_addr;
        else if (mem_addr !== first_ma) stable = 1'b0;
        if (mr_cyc == 3) begin
          mem_rdata = line_data(mem_addr);
          mem_resp  = 1'b1;
          mresp_cyc = cyc;
        end
      end
    end
    if (!hold) cpu_read = 1'b0;
    if (miss) exp_misses++;
    else exp_hits++;
    check_eq({tag, "_latency"}, resp_cyc, miss ? (mresp_cyc + 2) : 2);
    check_eq({tag, "_rdata"}, rd, exp_word);
    check_eq({tag, "_memrd_cycles"}, mr_cyc, miss ? 3 : 0);
    if (miss) begin
      check_eq({tag, "_mem_addr"}, first_ma, line_a);
      check_eq({tag, "_mem_addr_stable"}, {31'b0, stable}, 32'd1);
    end
    check_eq({tag, "_hit_count"}, hit_count, exp_hits);
    check_eq({tag, "_miss_count"}, miss_count, exp_misses);
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_ack"}, {31'b0, flush_ack}, 32'd1);
    flush = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_ack_pulse"}, {31'b0, flush_ack}, 32'd0);
  endtask

  initial begin
    int wait_cnt;
    rst       = 1'b1;
    cpu_read  = 1'b0;
    cpu_addr  = '0;
    flush     = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_cpu_resp", {31'b0, cpu_resp}, 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_flush_ack", {31'b0, flush_ack}, 32'd0);
    check_eq("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);

    do_read("t1_cold", 32'h0000_1004, 1'b1, 1'b0);
    do_read("t2_hit", 32'h0000_101C, 1'b0, 1'b0);

    // Clear set 0 (the 0x1000 line lives there) so T3 fills ways 0..3 in order.
    do_flush("pre_t3_flush");
    do_read("t3_fill0", 32'h0000_0000, 1'b1, 1'b0);
    do_read("t3_fill1", 32'h0000_0100, 1'b1, 1'b0);
    do_read("t3_fill2", 32'h0000_0200, 1'b1, 1'b0);
    do_read("t3_fill3", 32'h0000_0300, 1'b1, 1'b0);
    do_read("t3_hit0", 32'h0000_0000, 1'b0, 1'b0);
    do_read("t3_fill4", 32'h0000_0400, 1'b1, 1'b0);
    do_read("t3_hit100", 32'h0000_0104, 1'b0, 1'b0);
    do_read("t3_hit300", 32'h0000_0308, 1'b0, 1'b0);
    do_read("t3_hit000", 32'h0000_0010, 1'b0, 1'b0);
    do_read("t3_miss200", 32'h0000_0200, 1'b1, 1'b0);

    do_flush("t4_flush");
    do_read("t4_miss100", 32'h0000_0100, 1'b1, 1'b0);

    // Stray fill response while idle must not disturb anything.
    mem_rdata = '1;
    mem_resp  = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_stray_cpu_resp", {31'b0, cpu_resp}, 32'd0);
    check_eq("t6_stray_mem_read", {31'b0, mem_read}, 32'd0);
    check_eq("t6_stray_hits", hit_count, exp_hits);
    check_eq("t6_stray_misses", miss_count, exp_misses);
    do_read("t6_after_stray", 32'h0000_0100, 1'b0, 1'b0);
    do_read("t6_b2b_0", 32'h0000_0104, 1'b0, 1'b1);
    do_read("t6_b2b_1", 32'h0000_0108, 1'b0, 1'b1);
    do_read("t6_b2b_2", 32'h0000_010C, 1'b0, 1'b0);

    // Reset in the middle of a fill.
    cpu_addr = 32'h0000_2000;
    cpu_read = 1'b1;
    wait_cnt = 0;
    while (!mem_read && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_eq("t5_mem_read_up", {31'b0, mem_read}, 32'd1);
    cpu_read = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t5_mem_read_drop", {31'b0, mem_read}, 32'd0);
    check_eq("t5_hit_count", hit_count, 32'd0);
    check_eq("t5_miss_count", miss_count, 32'd0);
    check_eq("t5_cpu_resp", {31'b0, cpu_resp}, 32'd0);
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    do_read("t5_reread", 32'h0000_2000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
